// File: rtl/sd_cmd_if.sv
// sd_cmd_if: command request/response fields, SD clock strobes and CMD pin bundle
interface sd_cmd_if;
  logic        i_sd_clk_rising;
  logic        i_sd_clk_falling;
  logic [5:0]  i_command_index;
  logic [31:0] i_command_argument;
  logic        i_command_long_response;
  logic        i_command_skip_response;
  logic        i_command_start;
  logic        o_command_busy;
  logic        o_command_timeout;
  logic        o_command_response_crc_error;
  logic [5:0]  o_command_index;
  logic [31:0] o_command_response;
  logic        o_sd_cmd_oe;
  logic        o_sd_cmd_out;
  logic        i_sd_cmd_in;
  modport master (
    output i_sd_clk_rising, i_sd_clk_falling, i_command_index, i_command_argument,
           i_command_long_response, i_command_skip_response, i_command_start, i_sd_cmd_in,
    input  o_command_busy, o_command_timeout, o_command_response_crc_error,
           o_command_index, o_command_response, o_sd_cmd_oe, o_sd_cmd_out
  );
  modport slave (
    input  i_sd_clk_rising, i_sd_clk_falling, i_command_index, i_command_argument,
           i_command_long_response, i_command_skip_response, i_command_start, i_sd_cmd_in,
    output o_command_busy, o_command_timeout, o_command_response_crc_error,
           o_command_index, o_command_response, o_sd_cmd_oe, o_sd_cmd_out
  );
endinterface

// File: rtl/sd_cmd.sv
// sd_cmd: SD CMD-line engine sending a 48-bit command and receiving/checking the response
module sd_cmd #(
  parameter int TIMEOUT_CLKS = 64,
  parameter int GAP_CLKS     = 8
) (
  input logic    i_clk,
  input logic    i_reset,
  sd_cmd_if.slave bus
);
  typedef enum logic [2:0] {IDLE, TX, WAIT_RSP, RX, GAP} state_t;
  state_t      r_state, w_next;
  logic [47:0] r_tx;
  logic [7:0]  r_bit;
  logic [15:0] r_cnt;
  logic        r_long, r_skip;
  logic [6:0]  r_crc;
  logic        r_oe, r_out, r_busy, r_timeout, r_crc_err;
  logic [5:0]  r_index;
  logic [31:0] r_resp;
  logic        w_rise, w_fall, w_in, w_last_rx, w_idx_bit, w_rsp_bit, w_crc_acc, w_crc_chk;
  logic [15:0] w_cnt_inc;
  logic [39:0] w_head;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    return {c[5:0], 1'b0} ^ ((c[6] ^ b) ? 7'h09 : 7'h00);
  endfunction

  function automatic logic [6:0] crc7_40(input logic [39:0] d);
    logic [6:0] c;
    c = '0;
    for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
    return c;
  endfunction

  // a falling strobe coinciding with a rising strobe is dropped
  assign w_rise    = bus.i_sd_clk_rising;
  assign w_fall    = bus.i_sd_clk_falling & ~bus.i_sd_clk_rising;
  assign w_in      = bus.i_sd_cmd_in;
  assign w_cnt_inc = r_cnt + 16'd1;
  assign w_head    = {2'b01, bus.i_command_index, bus.i_command_argument};
  // r_bit holds the position of the response bit being sampled in RX
  assign w_last_rx = r_bit == (r_long ? 8'd135 : 8'd47);
  assign w_idx_bit = r_bit >= 8'd2 && r_bit <= 8'd7;
  assign w_rsp_bit = r_long ? (r_bit >= 8'd103 && r_bit <= 8'd134) : (r_bit >= 8'd8 && r_bit <= 8'd39);
  assign w_crc_acc = !r_long && r_bit < 8'd40;
  assign w_crc_chk = !r_long && r_bit >= 8'd40 && r_bit <= 8'd46;

  assign bus.o_command_busy               = r_busy;
  assign bus.o_command_timeout            = r_timeout;
  assign bus.o_command_response_crc_error = r_crc_err;
  assign bus.o_command_index              = r_index;
  assign bus.o_command_response           = r_resp;
  assign bus.o_sd_cmd_oe                  = r_oe;
  assign bus.o_sd_cmd_out                 = r_out;

  // state register
  always_ff @(posedge i_clk) begin
    r_state <= i_reset ? IDLE : w_next;
  end

  // next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = bus.i_command_start ? TX : IDLE;
      TX:       if (w_fall && r_bit == 8'd48) w_next = r_skip ? GAP : WAIT_RSP;
      WAIT_RSP: if (w_rise) w_next = !w_in ? RX : (w_cnt_inc == 16'(TIMEOUT_CLKS)) ? GAP : WAIT_RSP;
      RX:       if (w_rise && w_last_rx) w_next = GAP;
      GAP:      if (w_rise && w_cnt_inc == 16'(GAP_CLKS)) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // frame shifting, response capture, CRC check and counters
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tx      <= '0;
      r_bit     <= '0;
      r_cnt     <= '0;
      r_long    <= 1'b0;
      r_skip    <= 1'b0;
      r_crc     <= '0;
      r_oe      <= 1'b0;
      r_out     <= 1'b1;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_crc_err <= 1'b0;
      r_index   <= '0;
      r_resp    <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.i_command_start) begin
          r_tx      <= {w_head, crc7_40(w_head), 1'b1};
          r_bit     <= '0;
          r_cnt     <= '0;
          r_long    <= bus.i_command_long_response;
          r_skip    <= bus.i_command_skip_response;
          r_busy    <= 1'b1;
          r_timeout <= 1'b0;
          r_crc_err <= 1'b0;
        end
        TX: if (w_fall) begin
          if (r_bit == 8'd48) begin
            r_oe  <= 1'b0;
            r_out <= 1'b1;
            r_cnt <= '0;
          end else begin
            r_oe  <= 1'b1;
            r_out <= r_tx[47];
            r_tx  <= {r_tx[46:0], 1'b0};
            r_bit <= r_bit + 8'd1;
          end
        end
        WAIT_RSP: if (w_rise) begin
          if (!w_in) begin
            r_bit <= 8'd1;
            r_crc <= '0;
          end else if (w_cnt_inc == 16'(TIMEOUT_CLKS)) begin
            r_timeout <= 1'b1;
            r_cnt     <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        RX: if (w_rise) begin
          r_bit <= r_bit + 8'd1;
          if (w_idx_bit) r_index <= {r_index[4:0], w_in};
          if (w_rsp_bit) r_resp <= {r_resp[30:0], w_in};
          if (w_crc_acc) r_crc <= crc7_step(r_crc, w_in);
          if (w_crc_chk) begin
            r_crc <= {r_crc[5:0], 1'b0};
            if (w_in != r_crc[6]) r_crc_err <= 1'b1;
          end
          if (w_last_rx) r_cnt <= '0;
        end
        GAP: if (w_rise) begin
          r_cnt <= w_cnt_inc;
          if (w_cnt_inc == 16'(GAP_CLKS)) r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sd_cmd.sv
// tb_sd_cmd: table-driven check of sd_cmd against a CMD-line responder model
module tb_sd_cmd;
  logic clk, i_reset;
  int errors, checks;
  int rsp_req, rsp_ack, rsp_left, rsp_wait;
  logic [135:0] rsp_sh;
  sd_cmd_if bus();

  sd_cmd #(.TIMEOUT_CLKS(64), .GAP_CLKS(8)) dut (.i_clk(clk), .i_reset(i_reset), .bus(bus.slave));

  typedef struct {
    logic [5:0]   idx;
    logic [31:0]  arg;
    logic         lng, skip, reply;
    int           wt;
    logic [135:0] rsp;
    int           len;
    logic [47:0]  tx;
    logic         to, crc;
    logic [5:0]   ridx;
    logic [31:0]  rresp;
    int           idle;
    logic         poke;
  } vec_t;
  vec_t tbl[5];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SD clock strobes every 4 system clocks; responder drives CMD on falling strobes
  initial begin
    int ph, g_left, g_wait;
    logic [135:0] g_sh;
    logic go, prev_oe;
    ph = 0; go = 1'b0; prev_oe = 1'b0; g_left = 0; g_wait = 0; g_sh = '0;
    bus.i_sd_clk_rising = 1'b0;
    bus.i_sd_clk_falling = 1'b0;
    bus.i_sd_cmd_in = 1'b1;
    forever begin
      @(negedge clk);
      ph = (ph + 1) % 4;
      bus.i_sd_clk_rising = (ph == 0);
      bus.i_sd_clk_falling = (ph == 2);
      if (ph == 2) begin
        if (go) begin
          if (g_wait > 0) g_wait--;
          else if (g_left > 0) begin
            bus.i_sd_cmd_in = g_sh[135];
            g_sh = g_sh << 1;
            g_left--;
          end else begin
            bus.i_sd_cmd_in = 1'b1;
            go = 1'b0;
          end
        end else if (rsp_req != rsp_ack && prev_oe && !bus.o_sd_cmd_oe) begin
          go = 1'b1; rsp_ack = rsp_req; g_sh = rsp_sh; g_left = rsp_left; g_wait = rsp_wait;
        end
        prev_oe = bus.o_sd_cmd_oe;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, "_oe"}, 64'(bus.o_sd_cmd_oe), 64'd0);
    chk({name, "_out"}, 64'(bus.o_sd_cmd_out), 64'd1);
    chk({name, "_busy"}, 64'(bus.o_command_busy), 64'd0);
    chk({name, "_timeout"}, 64'(bus.o_command_timeout), 64'd0);
    chk({name, "_crcerr"}, 64'(bus.o_command_response_crc_error), 64'd0);
    chk({name, "_index"}, 64'(bus.o_command_index), 64'd0);
    chk({name, "_resp"}, 64'(bus.o_command_response), 64'd0);
  endtask

  task automatic run(input vec_t v, input int abort_bit);
    logic [47:0] tx;
    int oe_n, rises, to_at, idle_at, cyc;
    logic f, r, done_tx;
    tx = '0; oe_n = 0; rises = 0; to_at = -1; idle_at = -1; cyc = 0; done_tx = 1'b0;
    if (v.reply) begin
      rsp_sh = v.rsp; rsp_left = v.len; rsp_wait = v.wt; rsp_req++;
    end
    @(negedge clk);
    bus.i_command_index = v.idx;
    bus.i_command_argument = v.arg;
    bus.i_command_long_response = v.lng;
    bus.i_command_skip_response = v.skip;
    bus.i_command_start = 1'b1;
    @(negedge clk);
    bus.i_command_start = 1'b0;
    for (int c = 0; c < 4000 && idle_at < 0; c++) begin
      @(posedge clk);
      f = bus.i_sd_clk_falling;
      r = bus.i_sd_clk_rising;
      #1;
      cyc++;
      if (v.poke && c == 300) begin
        bus.i_command_index = 6'h11;
        bus.i_command_start = 1'b1;
      end else bus.i_command_start = 1'b0;
      if (f && bus.o_sd_cmd_oe) begin
        tx = {tx[46:0], bus.o_sd_cmd_out};
        oe_n++;
      end
      if (abort_bit > 0 && oe_n == abort_bit) begin
        i_reset = 1'b1;
        @(posedge clk);
        #1;
        i_reset = 1'b0;
        chk_reset_state("abort");
        return;
      end
      if (r && done_tx) rises++;
      if (oe_n > 0 && !bus.o_sd_cmd_oe) done_tx = 1'b1;
      if (bus.o_command_timeout && to_at < 0) to_at = rises;
      if (!bus.o_command_busy) idle_at = rises;
    end
    bus.i_command_start = 1'b0;
    chk("tx_frame", 64'(tx), 64'(v.tx));
    chk("oe_strobes", 64'(oe_n), 64'd48);
    chk("rises_to_idle", 64'(idle_at), 64'(v.idle));
    chk("timeout", 64'(bus.o_command_timeout), 64'(v.to));
    chk("timeout_at", 64'(to_at), v.to ? 64'd64 : 64'(-1));
    chk("crc_error", 64'(bus.o_command_response_crc_error), 64'(v.crc));
    chk("rsp_index", 64'(bus.o_command_index), 64'(v.ridx));
    chk("rsp_payload", 64'(bus.o_command_response), 64'(v.rresp));
    chk("idle_oe", 64'(bus.o_sd_cmd_oe), 64'd0);
    chk("idle_out", 64'(bus.o_sd_cmd_out), 64'd1);
    if (v.skip) chk("busy_cycles_56sd", 64'(cyc >= 220 && cyc <= 228), 64'd1);
    if (v.poke) begin
      repeat (40) @(posedge clk);
      #1;
      chk("ignored_start_busy", 64'(bus.o_command_busy), 64'd0);
      chk("ignored_start_oe", 64'(bus.o_sd_cmd_oe), 64'd0);
    end
  endtask

  initial begin
    errors = 0; checks = 0; rsp_req = 0; rsp_ack = 0; rsp_left = 0; rsp_wait = 0; rsp_sh = '0;
    i_reset = 1'b1;
    bus.i_command_index = '0;
    bus.i_command_argument = '0;
    bus.i_command_long_response = 1'b0;
    bus.i_command_skip_response = 1'b0;
    bus.i_command_start = 1'b0;
    // idle rises = (wait + 2 idle samples before the start bit) + response length + gap
    tbl[0] = '{idx: 6'd0, arg: 32'h0, lng: 1'b0, skip: 1'b1, reply: 1'b0, wt: 0, rsp: '0, len: 0,
               tx: 48'h400000000095, to: 1'b0, crc: 1'b0, ridx: 6'h00, rresp: 32'h0, idle: 8, poke: 1'b0};
    tbl[1] = '{idx: 6'd8, arg: 32'h1AA, lng: 1'b0, skip: 1'b0, reply: 1'b1, wt: 5,
               rsp: {48'h08000001AA13, 88'h0}, len: 48, tx: 48'h48000001AA87, to: 1'b0, crc: 1'b0,
               ridx: 6'd8, rresp: 32'h1AA, idle: 63, poke: 1'b0};
    tbl[2] = '{idx: 6'd8, arg: 32'h1AA, lng: 1'b0, skip: 1'b0, reply: 1'b1, wt: 5,
               rsp: {48'h08000001AA29, 88'h0}, len: 48, tx: 48'h48000001AA87, to: 1'b0, crc: 1'b1,
               ridx: 6'd8, rresp: 32'h1AA, idle: 63, poke: 1'b0};
    tbl[3] = '{idx: 6'd2, arg: 32'h0, lng: 1'b1, skip: 1'b0, reply: 1'b1, wt: 5,
               rsp: {2'b00, 6'h3F, 95'h1234_5678_9ABC_DEF0_1357_9BDF, 32'hDEADBEEF, 1'b1}, len: 136,
               tx: 48'h42000000004D, to: 1'b0, crc: 1'b0, ridx: 6'h3F, rresp: 32'hDEADBEEF, idle: 151, poke: 1'b0};
    tbl[4] = '{idx: 6'd55, arg: 32'h0, lng: 1'b0, skip: 1'b0, reply: 1'b0, wt: 0, rsp: '0, len: 0,
               tx: 48'h770000000065, to: 1'b1, crc: 1'b0, ridx: 6'h3F, rresp: 32'hDEADBEEF, idle: 72, poke: 1'b1};
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("reset");
    i_reset = 1'b0;
    for (int i = 0; i < 5; i++) run(tbl[i], 0);
    run('{idx: 6'd17, arg: 32'h12345678, lng: 1'b0, skip: 1'b0, reply: 1'b0, wt: 0, rsp: '0, len: 0,
          tx: '0, to: 1'b0, crc: 1'b0, ridx: '0, rresp: '0, idle: 0, poke: 1'b0}, 20);
    run(tbl[0], 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
